dffe_pipe: RTL and testbench
============================

# dffe_pipe

Parametrised pipeline register, the successor to the plain 32-bit enabled flop used for PC and inter-phase registers. Carries a WIDTH-bit word between two datapath stages with a valid/ready handshake, an optional two-entry skid buffer for full throughput with a registered ready, and a synchronous flush. It sits between datapath stages, e.g. PC → fetch or IR → decode, wherever back-pressure or squash is needed.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- RST_VAL, 0, value loaded into q (and skid register) on reset
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register, combinational in_ready
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all held beats
- in_valid  in  1  upstream beat present on d
- in_ready  out  1  block can accept a beat this cycle
- d  in  WIDTH  upstream data
- out_valid  out  1  q holds a valid beat
- out_ready  in  1  downstream accepts q this cycle
- q  out  WIDTH  head-of-pipe data
- count  out  2  beats held: 0, 1 or 2 (2 only when SKID=1)

## Operation
- Accept: in_valid & in_ready at a rising edge. Drain: out_valid & out_ready at a rising edge.
- States (SKID=1): EMPTY (count 0), ONE (main full), TWO (main + skid full).
  - EMPTY: accept → ONE, q←d.
  - ONE: accept only → TWO, skid←d; drain only → EMPTY; accept+drain → ONE, q←d; neither → hold.
  - TWO: in_ready=0; drain → ONE, q←skid; no drain → hold.
- in_ready (SKID=1) = flop output, 1 exactly when state ≠ TWO; never depends combinationally on out_ready.
- SKID=0: states EMPTY/ONE only; in_ready = ~out_valid | out_ready (combinational); accept+drain in same cycle → stays ONE with q←d.
- out_valid = (state ≠ EMPTY); count encodes state.
- flush (priority over everything): next state EMPTY, out_valid=0, in_ready=1. A beat offered in the flush cycle is consumed and discarded if in_ready was 1; q and skid data retain last values (not reset).
- Data never changes while state is ONE/TWO without a drain or an accept into main (q stable under stall).
- No data is duplicated or dropped except by flush.

## Timing
- Reset (async, immediate on rst rising): q=RST_VAL, skid=RST_VAL, out_valid=0, count=0, in_ready=1. While rst high no transfer occurs regardless of in_valid/out_ready.
- Reset mid-operation: held beats lost; first accept possible at first rising edge with rst low.
- Latency: d accepted at edge N → visible on q, out_valid=1 after edge N (same-cycle data at N+1 cycle).
- Throughput: 1 beat/cycle in both modes when out_ready held high.
- SKID=1: out_ready low at edge N with state ONE and accept → in_ready low after N; in_ready returns high after first drain edge.
- flush asserted at edge N: out_valid=0, count=0 after N; accept possible at N+1.

## Test plan
- Reset: assert rst mid-clock with q=0xDEADBEEF valid, RST_VAL=0x1234 → q=0x1234, out_valid=0, count=0 before next edge.
- Streaming: in_valid=1, out_ready=1, d=1,2,3,…,100 per cycle → q emits 1..100 in order one cycle later, no bubbles, in_ready stays 1 (both SKID values).
- Back-pressure (SKID=1): send 0xA, 0xB with out_ready=0 → count=2, in_ready=0, q=0xA held; raise out_ready → 0xA then 0xB drained, count 2→1→0, in_ready high after first drain.
- Back-pressure (SKID=0): out_ready=0 with q=0x5 valid → in_ready=0 same cycle, q stays 0x5; out_ready=1 with in_valid, d=0x6 → q=0x6 next edge.
- Flush: count=2, flush=1 with in_valid=1, d=0x77 → count=0, out_valid=0 next edge, 0x77 never appears on q.
- Random: random in_valid/out_ready/flush (5%) for 10k cycles against scoreboard → order preserved, no loss except flushed beats, count matches model.

Source files
------------

// File: rtl/dffe_pipe.sv
// Pipeline register with a valid/ready handshake, an optional two-entry skid buffer and a synchronous flush.
// Data words move through main (q) and skid registers. The registers themselves are not cleared on flush.
module dffe_pipe #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit               SKID    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             accept;
    logic             drain;

    assign out_valid = (state_q != EMPTY);
    assign count     = state_q;
    assign q         = data_q;
    // Without the skid entry, a full register can only take a beat while it is being drained.
    assign in_ready  = SKID ? in_ready_q : (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    data_d  = d;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    data_d = d;
                end else if (accept && SKID) begin
                    state_d = TWO;
                    skid_d  = d;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    state_d = ONE;
                    data_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush discards any held beat and whatever is offered, but leaves the data registers untouched.
        if (flush) begin
            state_d = EMPTY;
            data_d  = data_q;
            skid_d  = skid_q;
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            data_q     <= RST_VAL;
            skid_q     <= RST_VAL;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_dffe_pipe.sv
// Drives a SKID=1 instance and a SKID=0 instance from shared stimulus.
// Each instance is checked against its own queue model of the beats it holds.
module tb_dffe_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] d;
    logic        out_ready;
    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [31:0] q1, q0;
    logic [1:0]  count1, count0;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          verbose  = 1'b1;
    logic [31:0] m1[$];
    logic [31:0] m0[$];

    dffe_pipe #(.WIDTH(32), .RST_VAL(32'h1234), .SKID(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .d(d), .out_valid(out_valid1), .out_ready(out_ready), .q(q1), .count(count1)
    );

    dffe_pipe #(.WIDTH(32), .RST_VAL(32'h0), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .d(d), .out_valid(out_valid0), .out_ready(out_ready), .q(q0), .count(count0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the model by one edge using the inputs now applied, then step to just after the edge.
    task automatic tick();
        bit rdy1, rdy0;
        logic [31:0] v;
        rdy1 = (m1.size() != 2);
        rdy0 = (m0.size() == 0) || out_ready;
        if (!rst) begin
            if (flush) begin
                m1.delete();
                m0.delete();
            end else begin
                if (m1.size() > 0 && out_ready) begin
                    v = m1.pop_front();
                    if (verbose) $display("dut1 beat out 0x%08h", v);
                end
                if (m0.size() > 0 && out_ready) begin
                    v = m0.pop_front();
                    if (verbose) $display("dut0 beat out 0x%08h", v);
                end
                if (in_valid && rdy1) m1.push_back(d);
                if (in_valid && rdy0) m0.push_back(d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({in_ready1, out_valid1, count1, q1} !== {1'b1, 1'b0, 2'd0, 32'h1234}) begin
            n_fail++;
            $display("FAIL reset_init: got rdy=%0b v=%0b cnt=%0d q=%h, want 1 0 0 1234", in_ready1, out_valid1, count1, q1);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; d = 32'hDEADBEEF; out_ready = 1'b0;
        tick();
        n_checks++;
        if ({out_valid1, q1} !== {1'b1, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL reset_load: got v=%0b q=%h, want 1 deadbeef", out_valid1, q1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        m1.delete();
        m0.delete();
        n_checks++;
        if ({in_ready1, out_valid1, count1, q1} !== {1'b1, 1'b0, 2'd0, 32'h1234}) begin
            n_fail++;
            $display("FAIL reset_async: got rdy=%0b v=%0b cnt=%0d q=%h, want 1 0 0 1234", in_ready1, out_valid1, count1, q1);
        end
        n_checks++;
        if ({out_valid0, q0} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_async0: got v=%0b q=%h, want 0 0", out_valid0, q0);
        end
        in_valid = 1'b1; d = 32'h55; out_ready = 1'b1;
        tick();
        n_checks++;
        if ({count1, count0} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got cnt1=%0d cnt0=%0d, want 0 0", count1, count0);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            in_valid = 1'b1; d = i; out_ready = 1'b1;
            #1;
            n_checks++;
            if ({in_ready1, in_ready0} !== 2'b11) begin
                n_fail++;
                $display("FAIL stream_ready[%0d]: got rdy1=%0b rdy0=%0b, want 1 1", i, in_ready1, in_ready0);
            end
            if (i > 1) begin
                n_checks++;
                if ({out_valid1, q1, out_valid0, q0} !== {1'b1, 32'(i - 1), 1'b1, 32'(i - 1)}) begin
                    n_fail++;
                    $display("FAIL stream_data[%0d]: got q1=%0d q0=%0d v=%0b%0b, want %0d", i, q1, q0, out_valid1, out_valid0, i - 1);
                end
            end
            tick();
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({q1, q0} !== {32'd100, 32'd100}) begin
            n_fail++;
            $display("FAIL stream_last: got q1=%0d q0=%0d, want 100", q1, q0);
        end
        tick();
        n_checks++;
        if ({count1, count0} !== 4'd0) begin
            n_fail++;
            $display("FAIL stream_empty: got cnt1=%0d cnt0=%0d, want 0 0", count1, count0);
        end
    endtask

    task automatic test_backpressure_skid();
        @(negedge clk);
        in_valid = 1'b1; d = 32'hA; out_ready = 1'b0;
        tick();
        @(negedge clk);
        d = 32'hB;
        tick();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({count1, in_ready1, q1} !== {2'd2, 1'b0, 32'hA}) begin
            n_fail++;
            $display("FAIL bp_full: got cnt=%0d rdy=%0b q=%h, want 2 0 a", count1, in_ready1, q1);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if ({count1, in_ready1, q1} !== {2'd1, 1'b1, 32'hB}) begin
            n_fail++;
            $display("FAIL bp_drain1: got cnt=%0d rdy=%0b q=%h, want 1 1 b", count1, in_ready1, q1);
        end
        tick();
        n_checks++;
        if ({count1, out_valid1, count0} !== {2'd0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL bp_drain2: got cnt1=%0d v=%0b cnt0=%0d, want 0 0 0", count1, out_valid1, count0);
        end
    endtask

    task automatic test_backpressure_noskid();
        @(negedge clk);
        in_valid = 1'b1; d = 32'h5; out_ready = 1'b1;
        tick();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++;
        if ({in_ready0, q0} !== {1'b0, 32'h5}) begin
            n_fail++;
            $display("FAIL bp0_stall: got rdy=%0b q=%h, want 0 5", in_ready0, q0);
        end
        tick();
        n_checks++;
        if ({count0, q0} !== {2'd1, 32'h5}) begin
            n_fail++;
            $display("FAIL bp0_hold: got cnt=%0d q=%h, want 1 5", count0, q0);
        end
        @(negedge clk);
        in_valid = 1'b1; d = 32'h6; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp0_ready: got rdy=%0b, want 1", in_ready0);
        end
        tick();
        n_checks++;
        if ({count0, q0, q1} !== {2'd1, 32'h6, 32'h6}) begin
            n_fail++;
            $display("FAIL bp0_replace: got cnt0=%0d q0=%h q1=%h, want 1 6 6", count0, q0, q1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        @(negedge clk);
        in_valid = 1'b1; d = 32'h11; out_ready = 1'b0;
        tick();
        @(negedge clk);
        d = 32'h22;
        tick();
        @(negedge clk);
        flush = 1'b1; d = 32'h77;
        #1;
        n_checks++;
        if (count1 !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_pre: got cnt=%0d, want 2", count1);
        end
        tick();
        n_checks++;
        if ({count1, out_valid1, in_ready1, q1, count0} !== {2'd0, 1'b0, 1'b1, 32'h11, 2'd0}) begin
            n_fail++;
            $display("FAIL flush_post: got cnt=%0d v=%0b rdy=%0b q=%h cnt0=%0d, want 0 0 1 11 0", count1, out_valid1, in_ready1, q1, count0);
        end
        @(negedge clk);
        flush = 1'b0; d = 32'h88;
        tick();
        n_checks++;
        if ({count1, q1, q0} !== {2'd1, 32'h88, 32'h88}) begin
            n_fail++;
            $display("FAIL flush_next: got cnt=%0d q1=%h q0=%h, want 1 88 88", count1, q1, q0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        verbose = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 99) < 5);
            d         = $urandom;
            #1;
            n_checks++;
            if ({in_ready1, out_valid1, count1} !== {m1.size() != 2, m1.size() != 0, 2'(m1.size())}) begin
                n_fail++;
                $display("FAIL rand_ctl1[%0d]: got rdy=%0b v=%0b cnt=%0d, want model count %0d", c, in_ready1, out_valid1, count1, m1.size());
            end
            n_checks++;
            if ({in_ready0, out_valid0, count0} !== {(m0.size() == 0) || out_ready, m0.size() != 0, 2'(m0.size())}) begin
                n_fail++;
                $display("FAIL rand_ctl0[%0d]: got rdy=%0b v=%0b cnt=%0d, want model count %0d", c, in_ready0, out_valid0, count0, m0.size());
            end
            if (m1.size() > 0) begin
                n_checks++;
                if (q1 !== m1[0]) begin
                    n_fail++;
                    $display("FAIL rand_q1[%0d]: got %h, want %h", c, q1, m1[0]);
                end
            end
            if (m0.size() > 0) begin
                n_checks++;
                if (q0 !== m0[0]) begin
                    n_fail++;
                    $display("FAIL rand_q0[%0d]: got %h, want %h", c, q0, m0[0]);
                end
            end
            tick();
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; d = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_streaming();
        test_backpressure_skid();
        test_backpressure_noskid();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
